// File: rtl/visca_reply_rx.sv
// VISCA reply parser: turns the camera UART RX byte stream into ACK / Completion /
// Error / zoom-position events (one-cycle strobes) plus held status registers.
// Latency: 1 cycle from the byte carrying 0xFF or the error-causing byte. No backpressure; a byte every cycle is accepted.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   rx_data, rx_valid   received byte and its one-cycle strobe
//   busy                packet in progress
//   ack_stb, cmpl_stb, err_stb, zoom_stb, frame_err_stb   one-cycle event strobes
//   socket, err_code, zoom_pos                            held reply fields
module visca_reply_rx #(
  parameter int CAM_ADDR    = 1,
  parameter int MAX_LEN     = 14,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        busy,
  output logic        ack_stb,
  output logic        cmpl_stb,
  output logic        err_stb,
  output logic [3:0]  socket,
  output logic [7:0]  err_code,
  output logic [15:0] zoom_pos,
  output logic        zoom_stb,
  output logic        frame_err_stb
);

  // Reply header: 1, camera address, 0000 (0x90 for address 1).
  localparam logic [7:0] HDR = {1'b1, 3'(CAM_ADDR), 4'h0};
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, BODY, DISCARD} state_t;

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [TW-1:0]  tcnt, tcnt_n;
  logic [7:0]     body   [5];
  logic [7:0]     body_n [5];
  logic           ack_n, cmpl_n, err_n, zoom_n, ferr_n;
  logic [3:0]     socket_n;
  logic [7:0]     err_code_n;
  logic [15:0]    zoom_pos_n;
  logic           timeout;

  // The byte wins over an expiring timer: timeout only fires on a cycle without rx_valid.
  assign timeout = !rx_valid && (state != IDLE) && (tcnt == TW'(TIMEOUT_CYC));

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    tcnt_n     = tcnt;
    body_n     = body;
    ack_n      = 1'b0;
    cmpl_n     = 1'b0;
    err_n      = 1'b0;
    zoom_n     = 1'b0;
    ferr_n     = 1'b0;
    socket_n   = socket;
    err_code_n = err_code;
    zoom_pos_n = zoom_pos;

    if (rx_valid)
      tcnt_n = '0;
    else if (state != IDLE)
      tcnt_n = tcnt + TW'(1);
    else
      tcnt_n = '0;

    case (state)
      IDLE: begin
        if (rx_valid && rx_data == HDR) begin
          state_n = BODY;
          cnt_n   = '0;
        end
      end

      BODY: begin
        if (rx_valid) begin
          if (rx_data == 8'hFF) begin
            state_n = IDLE;
            // Decode on the terminator; cnt is the body length.
            if (cnt == CW'(1) && body[0][7:4] == 4'h4) begin
              ack_n    = 1'b1;
              socket_n = body[0][3:0];
            end else if (cnt == CW'(1) && body[0][7:4] == 4'h5) begin
              cmpl_n   = 1'b1;
              socket_n = body[0][3:0];
            end else if (cnt == CW'(2) && body[0][7:4] == 4'h6) begin
              err_n      = 1'b1;
              socket_n   = body[0][3:0];
              err_code_n = body[1];
            end else if (cnt == CW'(5) && body[0] == 8'h50 &&
                         body[1][7:4] == 4'h0 && body[2][7:4] == 4'h0 &&
                         body[3][7:4] == 4'h0 && body[4][7:4] == 4'h0) begin
              zoom_n     = 1'b1;
              zoom_pos_n = {body[1][3:0], body[2][3:0], body[3][3:0], body[4][3:0]};
            end else begin
              ferr_n = 1'b1;
            end
          end else if (rx_data[7]) begin
            // Stray control byte: a fresh header restarts the packet, anything else aborts.
            ferr_n = 1'b1;
            if (rx_data == HDR)
              cnt_n = '0;
            else
              state_n = IDLE;
          end else if (cnt == CW'(MAX_LEN)) begin
            ferr_n  = 1'b1;
            state_n = DISCARD;
          end else begin
            // Only the first five body bytes matter for decoding.
            if (cnt < CW'(5))
              body_n[cnt[2:0]] = rx_data;
            cnt_n = cnt + CW'(1);
          end
        end
      end

      DISCARD: begin
        if (rx_valid && rx_data == 8'hFF)
          state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase

    if (timeout) begin
      state_n = IDLE;
      tcnt_n  = '0;
      ferr_n  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      tcnt          <= '0;
      for (int i = 0; i < 5; i++) body[i] <= 8'h00;
      busy          <= 1'b0;
      ack_stb       <= 1'b0;
      cmpl_stb      <= 1'b0;
      err_stb       <= 1'b0;
      zoom_stb      <= 1'b0;
      frame_err_stb <= 1'b0;
      socket        <= 4'h0;
      err_code      <= 8'h00;
      zoom_pos      <= 16'h0000;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      tcnt          <= tcnt_n;
      body          <= body_n;
      busy          <= (state_n != IDLE);
      ack_stb       <= ack_n;
      cmpl_stb      <= cmpl_n;
      err_stb       <= err_n;
      zoom_stb      <= zoom_n;
      frame_err_stb <= ferr_n;
      socket        <= socket_n;
      err_code      <= err_code_n;
      zoom_pos      <= zoom_pos_n;
    end
  end

endmodule

// File: tb/tb_visca_reply_rx.sv
// Bench for visca_reply_rx: directed reply sequences followed by random packets,
// checked by a queue-based scoreboard fed from a packet-level reference model.
module tb_visca_reply_rx;
  localparam int CAM_ADDR = 1;
  localparam int MAX_LEN  = 14;
  localparam int TO       = 100;
  localparam logic [7:0] HDR = 8'h90;

  localparam int K_ACK = 0, K_CMPL = 1, K_ERR = 2, K_ZOOM = 3, K_FERR = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        busy, ack_stb, cmpl_stb, err_stb, zoom_stb, frame_err_stb;
  logic [3:0]  socket;
  logic [7:0]  err_code;
  logic [15:0] zoom_pos;

  visca_reply_rx #(.CAM_ADDR(CAM_ADDR), .MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .ack_stb(ack_stb), .cmpl_stb(cmpl_stb), .err_stb(err_stb),
    .socket(socket), .err_code(err_code), .zoom_pos(zoom_pos),
    .zoom_stb(zoom_stb), .frame_err_stb(frame_err_stb)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    int          kind;
    int          at;
    int          tol;
    logic [3:0]  sock;
    logic [7:0]  ecode;
    logic [15:0] zpos;
    logic        bsy;
  } exp_t;
  exp_t sb[$];

  // ---------------- reference model ----------------
  // Mode: 0 waiting for header, 1 collecting body, 2 dropping until 0xFF.
  int          m_mode = 0;
  logic [7:0]  pkt[$];
  int          m_last = 0;
  logic [3:0]  m_sock = 4'h0;
  logic [7:0]  m_err  = 8'h00;
  logic [15:0] m_zoom = 16'h0000;

  function automatic void push_ev(input int kind, input int at, input int tol);
    exp_t e;
    e.kind = kind; e.at = at; e.tol = tol;
    e.sock = m_sock; e.ecode = m_err; e.zpos = m_zoom;
    e.bsy  = (m_mode != 0);
    sb.push_back(e);
  endfunction

  function automatic void decode(input int s);
    int n;
    logic [7:0] b[5];
    n = pkt.size();
    for (int i = 0; i < 5; i++) b[i] = (i < n) ? pkt[i] : 8'h00;
    if (n == 1 && b[0][7:4] == 4'h4) begin
      m_sock = b[0][3:0]; push_ev(K_ACK, s, 0);
    end else if (n == 1 && b[0][7:4] == 4'h5) begin
      m_sock = b[0][3:0]; push_ev(K_CMPL, s, 0);
    end else if (n == 2 && b[0][7:4] == 4'h6) begin
      m_sock = b[0][3:0]; m_err = b[1]; push_ev(K_ERR, s, 0);
    end else if (n == 5 && b[0] == 8'h50 && b[1] < 8'h10 && b[2] < 8'h10 &&
                 b[3] < 8'h10 && b[4] < 8'h10) begin
      m_zoom = 16'(b[1] * 4096 + b[2] * 256 + b[3] * 16 + b[4]);
      push_ev(K_ZOOM, s, 0);
    end else begin
      push_ev(K_FERR, s, 0);
    end
  endfunction

  function automatic void model_byte(input int s, input logic [7:0] d);
    m_last = s;
    if (m_mode == 0) begin
      if (d == HDR) begin m_mode = 1; pkt.delete(); end
    end else if (m_mode == 1) begin
      if (d == 8'hFF) begin
        m_mode = 0; decode(s);
      end else if (d >= 8'h80) begin
        if (d == HDR) pkt.delete(); else m_mode = 0;
        push_ev(K_FERR, s, 0);
      end else if (pkt.size() == MAX_LEN) begin
        m_mode = 2; push_ev(K_FERR, s, 0);
      end else begin
        pkt.push_back(d);
      end
    end else begin
      if (d == 8'hFF) m_mode = 0;
    end
  endfunction

  function automatic void model_idle(input int s);
    // Silence longer than the allowed gap ends the packet; timing allowed +-1 cycle.
    if (m_mode != 0 && s - m_last == TO + 1) begin
      m_mode = 0;
      push_ev(K_FERR, s, 1);
    end
  endfunction

  // One clock of stimulus; the byte is sampled by the DUT at edge number s.
  task automatic step(input logic v, input logic [7:0] d);
    int s;
    @(posedge clk);
    #1;
    rx_valid = v;
    rx_data  = d;
    s = cyc + 1;
    if (v) model_byte(s, d);
    else   model_idle(s);
  endtask

  logic [7:0] txq[$];

  task automatic send_txq(input int maxgap);
    for (int i = 0; i < txq.size(); i++) begin
      step(1'b1, txq[i]);
      repeat ($urandom_range(0, maxgap)) step(1'b0, 8'h00);
    end
    txq.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ack"}, ack_stb, 0);
    chk({tag, "_cmpl"}, cmpl_stb, 0);
    chk({tag, "_err"}, err_stb, 0);
    chk({tag, "_zoomstb"}, zoom_stb, 0);
    chk({tag, "_ferr"}, frame_err_stb, 0);
    chk({tag, "_socket"}, socket, 0);
    chk({tag, "_errcode"}, err_code, 0);
    chk({tag, "_zoompos"}, zoom_pos, 0);
  endtask

  task automatic model_reset();
    m_mode = 0; pkt.delete();
    m_sock = 4'h0; m_err = 8'h00; m_zoom = 16'h0000;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    int ns, kind, dt;
    exp_t e;
    if (!rst) begin
      while (sb.size() > 0 && sb[0].at + sb[0].tol < cyc) begin
        checks++; failures++;
        $display("FAIL missed_strobe: kind %0d due at cycle %0d, still absent at cycle %0d",
                 sb[0].kind, sb[0].at, cyc);
        void'(sb.pop_front());
      end
      ns = int'(ack_stb) + int'(cmpl_stb) + int'(err_stb) + int'(zoom_stb) + int'(frame_err_stb);
      if (ns > 1) chk("single_strobe", ns, 1);
      if (ns > 0) begin
        kind = ack_stb ? K_ACK : cmpl_stb ? K_CMPL : err_stb ? K_ERR : zoom_stb ? K_ZOOM : K_FERR;
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_strobe: kind %0d at cycle %0d, none expected", kind, cyc);
        end else begin
          e = sb.pop_front();
          chk("strobe_kind", kind, e.kind);
          dt = cyc - e.at;
          checks++;
          if (dt > e.tol || dt < -e.tol) begin
            failures++;
            $display("FAIL strobe_time: kind %0d at cycle %0d expected cycle %0d", kind, cyc, e.at);
          end
          chk("socket", socket, e.sock);
          chk("err_code", err_code, e.ecode);
          chk("zoom_pos", zoom_pos, e.zpos);
          chk("busy_at_strobe", busy, e.bsy);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [3:0] z;
    int t, n;

    #2 rst = 1'b1;
    #1 check_reset_vals("init");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();

    // ACK
    txq = '{HDR, 8'h41, 8'hFF}; send_txq(0);
    // Completion then Error back to back
    txq = '{HDR, 8'h51, 8'hFF, HDR, 8'h62, 8'h41, 8'hFF}; send_txq(0);
    // Zoom position, then a malformed one that must leave zoom_pos alone
    txq = '{HDR, 8'h50, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFF}; send_txq(0);
    txq = '{HDR, 8'h50, 8'h11, 8'h02, 8'h03, 8'h04, 8'hFF}; send_txq(0);
    // Noise, then overflow on the 15th body byte; trailing FF silent
    txq = '{8'h00, 8'hA0, HDR}; send_txq(0);
    repeat (15) txq.push_back(8'h01);
    txq.push_back(8'hFF); send_txq(0);
    repeat (3) step(1'b0, 8'h00);
    chk("busy_after_overflow", busy, 0);
    // Timeout, then a lone FF is ignored
    txq = '{HDR, 8'h41}; send_txq(0);
    repeat (TO + 5) step(1'b0, 8'h00);
    chk("busy_after_timeout", busy, 0);
    step(1'b1, 8'hFF);
    repeat (3) step(1'b0, 8'h00);

    // Reset mid-packet; remainder ignored until the next header
    txq = '{HDR, 8'h50, 8'h01}; send_txq(0);
    @(posedge clk); #1;
    rst = 1'b1; rx_valid = 1'b0;
    #1 check_reset_vals("midrst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    txq = '{8'h02, 8'h03, 8'h04, 8'hFF}; send_txq(0);
    txq = '{HDR, 8'h5A, 8'hFF}; send_txq(0);

    // Random traffic
    for (int it = 0; it < 250; it++) begin
      t = $urandom_range(0, 9);
      z = 4'($urandom_range(0, 15));
      case (t)
        0: txq = '{HDR, 8'h40 | 8'(z), 8'hFF};
        1: txq = '{HDR, 8'h50 | 8'(z), 8'hFF};
        2: txq = '{HDR, 8'h60 | 8'(z), 8'($urandom_range(0, 127)), 8'hFF};
        3, 4: begin
          txq = '{HDR, 8'h50};
          for (int k = 0; k < 4; k++) txq.push_back(8'($urandom_range(0, 15)));
          if (t == 4) begin
            n = $urandom_range(2, 5);
            txq[n] = txq[n] | 8'($urandom_range(1, 7) * 16);
          end
          txq.push_back(8'hFF);
        end
        5: begin
          txq = '{HDR};
          n = $urandom_range(0, 7);
          for (int k = 0; k < n; k++) txq.push_back(8'($urandom_range(0, 127)));
          txq.push_back(8'hFF);
        end
        6: begin
          n = $urandom_range(1, 4);
          for (int k = 0; k < n; k++) txq.push_back(8'($urandom_range(0, 255)));
        end
        7: begin
          txq = '{HDR};
          n = $urandom_range(13, 17);
          for (int k = 0; k < n; k++) txq.push_back(8'($urandom_range(0, 127)));
          txq.push_back(8'hFF);
        end
        8: begin
          txq = '{HDR, 8'h41};
          txq.push_back(($urandom_range(0, 1) == 1) ? HDR : 8'($urandom_range(128, 254)));
          txq.push_back(8'h50 | 8'(z));
          txq.push_back(8'hFF);
        end
        default: begin
          txq = '{HDR, 8'h41}; send_txq(0);
          repeat (TO + $urandom_range(0, 5)) step(1'b0, 8'h00);
          txq = '{8'hFF};
        end
      endcase
      send_txq(($urandom_range(0, 3) == 0) ? 3 : 0);
    end

    // Flush any open packet and let everything drain.
    step(1'b1, 8'hFF);
    repeat (TO + 10) step(1'b0, 8'h00);
    chk("scoreboard_empty", sb.size(), 0);
    chk("busy_final", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
